// File: rtl/shared_dff_arbiter.sv
// Round-robin owner arbiter and write sequencer for one shared
// WIDTH-bit register with complementary outputs.
module shared_dff_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           wr,
    input  logic [N_REQ*WIDTH-1:0]     din,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qn
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [OW-1:0]    ptr;
    logic [OW-1:0]    sel_idx;
    logic [OW-1:0]    nxt_ptr;
    logic             sel_found;
    logic [HW-1:0]    hold_cnt;
    logic [WIDTH-1:0] din_a [N_REQ];
    logic             own_req;
    logic             own_wr;
    logic             others;
    logic             last;

    for (genvar i = 0; i < N_REQ; i++) begin : g_din
        assign din_a[i] = din[i*WIDTH +: WIDTH];
    end

    // first set request at or above ptr, wrapping
    always_comb begin
        int j;
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!sel_found && req[j]) begin
                sel_found = 1'b1;
                sel_idx   = OW'(j);
            end
        end
    end

    assign own_req = req[owner];
    assign own_wr  = wr[owner];
    assign others  = |(req & ~gnt);
    assign last    = own_req && others &&
                     (hold_cnt >= HW'(MAX_HOLD - 1));
    assign nxt_ptr = (owner == OW'(N_REQ - 1)) ?
                     '0 : owner + 1'b1;

    assign busy = (state == BUSY);
    assign qn   = ~q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        gnt      <= N_REQ'(1) << sel_idx;
                        owner    <= sel_idx;
                        hold_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (own_req && own_wr)
                        q <= din_a[owner];
                    if (hold_cnt != HW'(MAX_HOLD))
                        hold_cnt <= hold_cnt + 1'b1;
                    // release and preempt both hand over via IDLE
                    if (!own_req || last) begin
                        gnt   <= '0;
                        ptr   <= nxt_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_dff_arbiter.sv
// Directed and randomized checks of shared_dff_arbiter against
// an owner/burst-length model of the arbitration rules.
module tb_shared_dff_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   wr;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   q;
    logic [W-1:0]   qn;

    int checks = 0;
    int errors = 0;

    // model: m_owner < 0 means nobody owns the register
    int           m_owner;
    int           m_ptr;
    int           m_n;
    logic [W-1:0] m_q;

    shared_dff_arbiter #(
        .N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr),
        .din(din), .gnt(gnt), .owner(owner),
        .busy(busy), .q(q), .qn(qn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_n     = 0;
        m_q     = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] oth;
        int o;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_n     = 0;
                end
            end
        end else begin
            o   = m_owner;
            m_n = m_n + 1;
            oth = req;
            oth[o] = 1'b0;
            if (!req[o]) begin
                m_owner = -1;
                m_ptr   = (o + 1) % N;
            end else begin
                if (wr[o]) m_q = din[o*W +: W];
                if (oth != 0 && m_n >= MH) begin
                    m_owner = -1;
                    m_ptr   = (o + 1) % N;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        logic [W-1:0] eqn;
        eg  = '0;
        eqn = ~m_q;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        if (m_owner >= 0)
            chk("owner", 64'(owner), 64'(m_owner));
        chk("q", 64'(q), 64'(m_q));
        chk("qn", 64'(qn), 64'(eqn));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic set_din(input int i, input logic [W-1:0] v);
        din[i*W +: W] = v;
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        chk("rst_q", 64'(q), 64'h00);
        chk("rst_gnt", 64'(gnt), 64'h0);
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        int gcount;
        rst = 1'b1;
        req = '0;
        wr  = '0;
        din = '0;
        model_reset();
        #2 rst = 1'b0;
        req = N'($urandom);
        wr  = N'($urandom);
        din = $urandom;
        #1;
        chk("reset_q", 64'(q), 64'h00);
        chk("reset_qn", 64'(qn), 64'hFF);
        chk("reset_gnt", 64'(gnt), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        step();
        step();

        req = '0; wr = '0; rst = 1'b1;
        step();
        req = 4'b0001;
        step();
        chk("first_gnt", 64'(gnt), 64'h1);
        req = '0;
        step();

        req = 4'b0010;
        step();
        chk("single_gnt", 64'(gnt), 64'h2);
        wr = 4'b0010;
        set_din(1, 8'hA5);
        step();
        chk("single_q", 64'(q), 64'hA5);
        chk("single_qn", 64'(qn), 64'h5A);
        req = '0; wr = '0;
        step();
        chk("single_idle", 64'(gnt), 64'h0);

        async_reset();
        req = 4'b1111;
        step();
        for (int r = 0; r < 5; r++) begin
            int o;
            o = r % N;
            chk("rr_owner", 64'(owner), 64'(o));
            wr = '0; wr[o] = 1'b1;
            set_din(o, 8'(8'h10 + o));
            step();
            chk("rr_q", 64'(q), 64'(8'h10 + o));
            req[o] = 1'b0; wr = '0;
            step();
            chk("rr_gap", 64'(gnt), 64'h0);
            req = 4'b1111;
            step();
        end
        req = '0;
        step();

        req = 4'b0001;
        step();
        gcount = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c >= 2) req[3] = 1'b1;
            wr = 4'b0001;
            set_din(0, 8'(c));
            if (gnt[0]) gcount++;
            step();
            if (c == 4) begin
                chk("pre_q", 64'(q), 64'h04);
                chk("pre_idle", 64'(gnt), 64'h0);
            end
            if (c == 5)
                chk("pre_next", 64'(gnt), 64'h8);
        end
        chk("pre_cycles", 64'(gcount), 64'd4);
        req = '0; wr = '0;
        step();

        req = 4'b0100;
        wr  = 4'b0010;
        set_din(1, 8'hFF);
        step();
        for (int c = 0; c < 10; c++) begin
            step();
            chk("sat_gnt", 64'(gnt), 64'h4);
            chk("sat_q_ff", 64'(q === 8'hFF), 64'h0);
        end

        wr = 4'b0100;
        set_din(2, 8'h3C);
        step();
        chk("mid_q", 64'(q), 64'h3C);
        wr = '0;
        async_reset();
        req = 4'b0101;
        step();
        chk("restart_gnt", 64'(gnt), 64'h1);
        req = 4'b0100;
        step();
        req = 4'b0101;
        step();
        chk("ptr1_gnt", 64'(gnt), 64'h4);

        req = '0; wr = '0;
        step();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                set_din(i, 8'($urandom));
            end
            wr = N'($urandom);
            if ($urandom_range(0, 149) == 0) async_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
